change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Converts a change amount into a sequence of 2-bit coin codes for the coin-hopper mechanism, one coin per valid/ack handshake.
- Uses the same coin-code encoding the coin decoder consumes: 00 = 1đ, 01 = 5đ, 10 = 10đ, 11 = invalid.
- Sits between the vending controller (start/amount/done) and the hopper driver.
- Uses greedy largest-coin-first selection. It falls back to smaller coins when a hopper reports empty.

Parameters:
- AMT_W, 8, width of the change amount and the remaining-amount register.
- ACK_TIMEOUT, 255, maximum cycles coin_valid may stay high without coin_ack before the error is raised. Must be ≥ 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- change_start  in  1  single-cycle request. Sampled only in IDLE.
- change_amount  in  AMT_W  amount in đ. Latched when change_start is accepted.
- hopper_empty  in  3  bit0 = 1đ, bit1 = 5đ, bit2 = 10đ; 1 means that hopper has no coins.
- coin_out  out  2  coin code being dispensed. Meaningful while coin_valid = 1.
- coin_valid  out  1  dispense request to the hopper driver.
- coin_ack  in  1  hopper driver has released the coin.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the full amount has been paid.
- error  out  1  one-cycle pulse when change cannot be completed (no usable coin, or ack timeout).
- remaining  out  AMT_W  amount still owed. Valid at all times and held after done/error until the next accepted start.
- coin_count  out  AMT_W  number of coins dispensed for the current request. Saturates at all-ones.

Behaviour:
- Reset (async, rst_n = 0): state = IDLE, coin_out = 00, coin_valid = 0, busy = 0, done = 0, error = 0, remaining = 0, coin_count = 0, timeout counter = 0. Reset mid-dispense drops coin_valid immediately. No coin is owed or resumed after reset.
- All outputs are registered.
- State machine states: IDLE, SELECT, ISSUE, DONE, ERROR.
- IDLE:
  - change_start = 1 → latch remaining = change_amount, clear coin_count, go to SELECT.
  - coin_ack is ignored.
- SELECT: one cycle, greedy pick evaluated in priority order:
  - remaining == 0 → DONE.
  - remaining ≥ 10 and !hopper_empty[2] → code 10.
  - else remaining ≥ 5 and !hopper_empty[1] → code 01.
  - else remaining ≥ 1 and !hopper_empty[0] → code 00.
  - else → ERROR.
  - When a coin is chosen: load coin_out, set coin_valid = 1, clear the timeout counter, go to ISSUE.
- ISSUE:
  - coin_out is held stable while coin_valid = 1.
  - coin_ack = 1: subtract the coin value from remaining, increment coin_count, drop coin_valid, go to SELECT.
  - Otherwise the counter increments. When the counter reaches ACK_TIMEOUT: drop coin_valid, go to ERROR; remaining is not decremented.
  - hopper_empty changes during ISSUE do not cancel the current coin.
- DONE: done = 1 for exactly one cycle, then IDLE.
- ERROR: error = 1 for exactly one cycle, then IDLE. remaining shows the unpaid amount.
- Latency:
  - Accepted start at edge t → coin_valid high after edge t+2.
  - Ack sampled at edge a → next coin_valid high after edge a+2.
  - Zero amount: done high after edge t+2.
- change_start while busy is ignored. It is not queued.
- coin_ack outside ISSUE is ignored.
- Subtraction never underflows: a coin is selected only if its value ≤ remaining.
- If change_start and rst_n deassertion coincide, the start is not guaranteed to be accepted.

Decomposition:
- Shared package coin_pkg: coin-code constants COIN_1 = 2'b00, COIN_5 = 2'b01, COIN_10 = 2'b10, COIN_INV = 2'b11; value constants 1/5/10; FSM state encoding. The coin decoder is migrated to the same constants.
- One sub-module, change_coin_select: combinational greedy picker. Inputs: remaining, hopper_empty. Outputs: coin code, coin value, found flag.

Test Plan:
- Amount 27, all hoppers full, immediate acks → coin_out 10,10,01,00,00; done pulse; remaining 0; coin_count 5.
- Amount 27, hopper_empty = 3'b100 → five × 01 then 00,00; done; coin_count 7.
- Amount 3, hopper_empty = 3'b001 → no coin_valid; error pulse 2 cycles after start; remaining 3.
- Amount 0 → done exactly 2 cycles after start; coin_valid never asserted.
- Amount 10, ACK_TIMEOUT = 4, coin_ack never asserted → coin_valid high 4 cycles; error pulse; remaining 10.
- Amount 15; assert rst_n = 0 while the first coin is valid → coin_valid, busy, remaining all 0 immediately. A second start with amount 5 after reset release → single 01 coin, done.

Source files
------------

// File: rtl/coin_pkg.sv
// ============================================================================
// coin_pkg : coin codes, coin values and dispenser FSM encoding
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package coin_pkg;

  localparam logic [1:0] COIN_1   = 2'b00;
  localparam logic [1:0] COIN_5   = 2'b01;
  localparam logic [1:0] COIN_10  = 2'b10;
  localparam logic [1:0] COIN_INV = 2'b11;

  localparam int VAL_1  = 1;
  localparam int VAL_5  = 5;
  localparam int VAL_10 = 10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_ISSUE  = 3'd2,
    S_DONE   = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/change_coin_select.sv
// ============================================================================
// change_coin_select : greedy largest-coin-first picker that skips empty hoppers
// Rev 1.0            : initial release
// ============================================================================
`default_nettype none

module change_coin_select
  import coin_pkg::*;
#(
  parameter int AMT_W = 8
) (
  input  logic [AMT_W-1:0] remaining,
  input  logic [2:0]       hopper_empty,
  output logic [1:0]       code,
  output logic [AMT_W-1:0] value,
  output logic             found
);

  always_comb begin
    code  = COIN_INV;
    value = '0;
    found = 1'b0;
    // A coin qualifies only if it fits, so the later subtraction cannot underflow.
    if (remaining >= AMT_W'(VAL_10) && !hopper_empty[2]) begin
      code  = COIN_10;
      value = AMT_W'(VAL_10);
      found = 1'b1;
    end else if (remaining >= AMT_W'(VAL_5) && !hopper_empty[1]) begin
      code  = COIN_5;
      value = AMT_W'(VAL_5);
      found = 1'b1;
    end else if (remaining >= AMT_W'(VAL_1) && !hopper_empty[0]) begin
      code  = COIN_1;
      value = AMT_W'(VAL_1);
      found = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/change_dispenser.sv
// ============================================================================
// change_dispenser : pays a change amount out one coin per valid/ack handshake
// Rev 1.0          : initial release
// ============================================================================
`default_nettype none

module change_dispenser
  import coin_pkg::*;
#(
  parameter int AMT_W       = 8,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             change_start,
  input  logic [AMT_W-1:0] change_amount,
  input  logic [2:0]       hopper_empty,
  output logic [1:0]       coin_out,
  output logic             coin_valid,
  input  logic             coin_ack,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [AMT_W-1:0] remaining,
  output logic [AMT_W-1:0] coin_count
);

  // The counter only has to reach ACK_TIMEOUT-1 before the timeout fires.
  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  state_t             state;
  state_t             state_nx;
  logic [CNT_W-1:0]   ack_cnt;
  logic [AMT_W-1:0]   coin_value;
  logic [1:0]         pick_code;
  logic [AMT_W-1:0]   pick_value;
  logic               pick_found;
  logic               acked;
  logic               timed_out;

  change_coin_select #(
    .AMT_W (AMT_W)
  ) u_select (
    .remaining    (remaining),
    .hopper_empty (hopper_empty),
    .code         (pick_code),
    .value        (pick_value),
    .found        (pick_found)
  );

  // The first ISSUE cycle raises coin_valid; the handshake is live only after that.
  assign acked     = (state == S_ISSUE) && coin_valid && coin_ack;
  assign timed_out = (state == S_ISSUE) && coin_valid && !coin_ack &&
                     (ack_cnt == CNT_W'(ACK_TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (change_start) state_nx = S_SELECT;
      S_SELECT: begin
        if (remaining == '0)  state_nx = S_DONE;
        else if (pick_found)  state_nx = S_ISSUE;
        else                  state_nx = S_ERROR;
      end
      S_ISSUE: begin
        if (acked)          state_nx = S_SELECT;
        else if (timed_out) state_nx = S_ERROR;
      end
      S_DONE:   state_nx = S_IDLE;
      S_ERROR:  state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      coin_out   <= COIN_1;
      coin_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      remaining  <= '0;
      coin_count <= '0;
      coin_value <= '0;
      ack_cnt    <= '0;
    end else begin
      state      <= state_nx;
      busy       <= (state_nx != S_IDLE);
      done       <= (state == S_DONE);
      error      <= (state == S_ERROR);
      coin_valid <= (state == S_ISSUE) && !acked && !timed_out;
      case (state)
        S_IDLE: begin
          if (change_start) begin
            remaining  <= change_amount;
            coin_count <= '0;
          end
        end
        S_SELECT: begin
          ack_cnt <= '0;
          if (remaining != '0 && pick_found) begin
            coin_out   <= pick_code;
            coin_value <= pick_value;
          end
        end
        S_ISSUE: begin
          if (acked) begin
            remaining <= remaining - coin_value;
            if (coin_count != '1) coin_count <= coin_count + 1'b1;
          end else if (coin_valid) begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_change_dispenser.sv
// ============================================================================
// tb_change_dispenser : directed self-checking bench for change_dispenser
// Rev 1.0             : initial release
// ============================================================================
`default_nettype none

module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       change_start = 1'b0;
  logic [7:0] change_amount = 8'd0;
  logic [2:0] hopper_empty = 3'b000;
  logic [1:0] coin_out;
  logic       coin_valid;
  logic       coin_ack = 1'b0;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] remaining;
  logic [7:0] coin_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0] got[$];
  int         rise_cyc[$];
  int         cyc, done_cyc, err_cyc, valid_cycles;
  bit         saw_done, saw_err;
  logic       prev_valid;

  change_dispenser #(
    .AMT_W       (8),
    .ACK_TIMEOUT (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .change_start  (change_start),
    .change_amount (change_amount),
    .hopper_empty  (hopper_empty),
    .coin_out      (coin_out),
    .coin_valid    (coin_valid),
    .coin_ack      (coin_ack),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .remaining     (remaining),
    .coin_count    (coin_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues a start, plays the hopper driver and records what it saw; cyc counts
  // edges after the accepting edge. glitch_cyc re-pulses change_start mid-run.
  task automatic run_change(input logic [7:0] amt, input logic [2:0] empty,
                            input bit do_ack, input int glitch_cyc);
    got.delete();
    rise_cyc.delete();
    saw_done = 0; saw_err = 0; cyc = 0; done_cyc = -1; err_cyc = -1;
    valid_cycles = 0; prev_valid = 1'b0;
    hopper_empty  = empty;
    change_amount = amt;
    change_start  = 1'b1;
    tick();
    change_start = 1'b0;
    while (!saw_done && !saw_err && cyc < 300) begin
      tick();
      cyc++;
      change_start = 1'b0;
      if (cyc == glitch_cyc) begin
        change_start  = 1'b1;
        change_amount = 8'd99;
      end
      if (done)  begin saw_done = 1; done_cyc = cyc; end
      if (error) begin saw_err = 1;  err_cyc = cyc;  end
      if (coin_valid) begin
        valid_cycles++;
        if (!prev_valid) begin
          got.push_back(coin_out);
          rise_cyc.push_back(cyc);
        end
      end
      prev_valid = coin_valid;
      coin_ack = (coin_valid && do_ack && !coin_ack);
    end
    change_start = 1'b0;
    coin_ack     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    if (coin_out !== 2'b00)   begin n_bad++; $display("FAIL reset_coin_out got %b want 00", coin_out); end
    n_cmp++;
    if (coin_valid !== 1'b0)  begin n_bad++; $display("FAIL reset_coin_valid got %b want 0", coin_valid); end
    n_cmp++;
    if (busy !== 1'b0)        begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++;
    if (done !== 1'b0 || error !== 1'b0) begin n_bad++; $display("FAIL reset_pulses got done=%b error=%b want 0/0", done, error); end
    n_cmp++;
    if (remaining !== 8'd0 || coin_count !== 8'd0) begin n_bad++; $display("FAIL reset_counts got rem=%0d cnt=%0d want 0/0", remaining, coin_count); end
    n_cmp++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_greedy_full();
    logic [1:0] exp_codes[5] = '{2'b10, 2'b10, 2'b01, 2'b00, 2'b00};
    hopper_empty  = 3'b000;
    change_amount = 8'd27;
    change_start  = 1'b1;
    tick();
    change_start = 1'b0;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_after_start got %b want 1", busy); end
    n_cmp++;
    // Re-issue the same start through the recorder (the extra IDLE trip is harmless).
    while (busy) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    run_change(8'd27, 3'b000, 1'b1, -1);
    if (got.size() !== 5) begin n_bad++; $display("FAIL greedy27_ncoins got %0d want 5", got.size()); end
    n_cmp++;
    for (int i = 0; i < 5; i++) begin
      if (i < got.size() && got[i] !== exp_codes[i]) begin
        n_bad++; $display("FAIL greedy27_coin%0d got %b want %b", i, got[i], exp_codes[i]);
      end
      if (i < got.size()) n_cmp++;
    end
    if (rise_cyc.size() < 2 || rise_cyc[0] !== 2 || rise_cyc[1] !== 5) begin
      n_bad++; $display("FAIL greedy27_latency got first=%0d second=%0d want 2/5",
                        rise_cyc.size() > 0 ? rise_cyc[0] : -1, rise_cyc.size() > 1 ? rise_cyc[1] : -1);
    end
    n_cmp++;
    if (!saw_done || done_cyc !== 17) begin n_bad++; $display("FAIL greedy27_done got cyc=%0d want 17", done_cyc); end
    n_cmp++;
    if (remaining !== 8'd0 || coin_count !== 8'd5) begin n_bad++; $display("FAIL greedy27_final got rem=%0d cnt=%0d want 0/5", remaining, coin_count); end
    n_cmp++;
    tick();
    if (done !== 1'b0) begin n_bad++; $display("FAIL greedy27_done_width got %b want 0", done); end
    n_cmp++;
  endtask

  task automatic test_empty_ten();
    run_change(8'd27, 3'b100, 1'b1, -1);
    if (got.size() !== 7) begin n_bad++; $display("FAIL no10_ncoins got %0d want 7", got.size()); end
    n_cmp++;
    for (int i = 0; i < 7; i++) begin
      if (i < got.size() && got[i] !== ((i < 5) ? 2'b01 : 2'b00)) begin
        n_bad++; $display("FAIL no10_coin%0d got %b want %b", i, got[i], (i < 5) ? 2'b01 : 2'b00);
      end
      if (i < got.size()) n_cmp++;
    end
    if (!saw_done || done_cyc !== 23) begin n_bad++; $display("FAIL no10_done got cyc=%0d want 23", done_cyc); end
    n_cmp++;
    if (remaining !== 8'd0 || coin_count !== 8'd7) begin n_bad++; $display("FAIL no10_final got rem=%0d cnt=%0d want 0/7", remaining, coin_count); end
    n_cmp++;
  endtask

  task automatic test_no_coin();
    run_change(8'd3, 3'b001, 1'b1, -1);
    if (!saw_err || err_cyc !== 2) begin n_bad++; $display("FAIL nocoin_error got cyc=%0d want 2", err_cyc); end
    n_cmp++;
    if (valid_cycles !== 0) begin n_bad++; $display("FAIL nocoin_valid got %0d cycles want 0", valid_cycles); end
    n_cmp++;
    if (remaining !== 8'd3 || busy !== 1'b0) begin n_bad++; $display("FAIL nocoin_state got rem=%0d busy=%b want 3/0", remaining, busy); end
    n_cmp++;
  endtask

  task automatic test_zero_amount();
    run_change(8'd0, 3'b000, 1'b1, -1);
    if (!saw_done || done_cyc !== 2) begin n_bad++; $display("FAIL zero_done got cyc=%0d want 2", done_cyc); end
    n_cmp++;
    if (valid_cycles !== 0 || coin_count !== 8'd0) begin n_bad++; $display("FAIL zero_coins got valid=%0d cnt=%0d want 0/0", valid_cycles, coin_count); end
    n_cmp++;
  endtask

  task automatic test_ack_timeout();
    run_change(8'd10, 3'b000, 1'b0, -1);
    if (got.size() !== 1 || got[0] !== 2'b10) begin n_bad++; $display("FAIL timeout_coin got n=%0d want one 10", got.size()); end
    n_cmp++;
    if (valid_cycles !== 4) begin n_bad++; $display("FAIL timeout_valid_len got %0d want 4", valid_cycles); end
    n_cmp++;
    if (!saw_err || err_cyc !== 7) begin n_bad++; $display("FAIL timeout_error got cyc=%0d want 7", err_cyc); end
    n_cmp++;
    if (remaining !== 8'd10 || coin_count !== 8'd0) begin n_bad++; $display("FAIL timeout_final got rem=%0d cnt=%0d want 10/0", remaining, coin_count); end
    n_cmp++;
  endtask

  task automatic test_start_while_busy();
    run_change(8'd5, 3'b000, 1'b1, 1);
    if (got.size() !== 1 || got[0] !== 2'b01) begin n_bad++; $display("FAIL busystart_coins got n=%0d want one 01", got.size()); end
    n_cmp++;
    if (!saw_done || remaining !== 8'd0 || coin_count !== 8'd1) begin
      n_bad++; $display("FAIL busystart_final got done=%0d rem=%0d cnt=%0d want 1/0/1", saw_done, remaining, coin_count);
    end
    n_cmp++;
  endtask

  task automatic test_reset_mid_dispense();
    int waited = 0;
    hopper_empty  = 3'b000;
    change_amount = 8'd15;
    change_start  = 1'b1;
    tick();
    change_start = 1'b0;
    while (!coin_valid && waited < 10) begin tick(); waited++; end
    if (coin_valid !== 1'b1 || coin_out !== 2'b10) begin n_bad++; $display("FAIL midrst_first_coin got valid=%b code=%b want 1/10", coin_valid, coin_out); end
    n_cmp++;
    #2;
    rst_n = 1'b0;
    #1;
    if (coin_valid !== 1'b0 || busy !== 1'b0 || remaining !== 8'd0) begin
      n_bad++; $display("FAIL midrst_async got valid=%b busy=%b rem=%0d want 0/0/0", coin_valid, busy, remaining);
    end
    n_cmp++;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    run_change(8'd5, 3'b000, 1'b1, -1);
    if (got.size() !== 1 || got[0] !== 2'b01 || !saw_done) begin
      n_bad++; $display("FAIL midrst_restart got n=%0d done=%0d want one 01 and done", got.size(), saw_done);
    end
    n_cmp++;
  endtask

  initial begin
    test_reset();
    test_greedy_full();
    test_empty_ten();
    test_no_coin();
    test_zero_amount();
    test_ack_timeout();
    test_start_while_busy();
    test_reset_mid_dispense();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish want finish before 200000");
    $fatal(1);
  end

endmodule

`default_nettype wire
